mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter W, default 16, SHALL set data width (BUS, MDR, memory data).
REQ-002 Parameter AW, default 16, SHALL set address width (MAR, Mem_Addr); AW <= W.
REQ-003 Parameter TIMEOUT, default 15, SHALL set the maximum number of ACCESS cycles with Mem_Ready low; 0 disables timeout.
REQ-004 Clk  in  1  the single clock; all state changes on its rising edge.
REQ-005 Reset_n  in  1  reset, synchronous, active-low.
REQ-006 BUS  in  W  datapath bus; source for MAR and MDR loads.
REQ-007 LD_MAR  in  1  load MAR from BUS[AW-1:0].
REQ-008 LD_MDR  in  1  load MDR from BUS.
REQ-009 Rd_Start  in  1  request a memory read.
REQ-010 Wr_Start  in  1  request a memory write.
REQ-011 Mem_Ready  in  1  memory completes the current access.
REQ-012 Mem_Rdata  in  W  read data from memory, valid when Mem_Ready=1.
REQ-013 Mem_Req  out  1  access in progress toward memory.
REQ-014 Mem_We  out  1  1 = write, 0 = read; meaningful only while Mem_Req=1.
REQ-015 Mem_Addr  out  AW  equals MAR.
REQ-016 Mem_Wdata  out  W  equals MDR.
REQ-017 MAR  out  AW  address register.
REQ-018 MDR  out  W  data register.
REQ-019 Busy  out  1  high in ACCESS and DONE.
REQ-020 Done  out  1  one-cycle pulse at completion of an access.
REQ-021 Err  out  1  sticky timeout flag.

Function
REQ-022 FSM states SHALL be IDLE, ACCESS, DONE; all outputs registered or decoded from state only.
REQ-023 In IDLE, LD_MAR/LD_MDR SHALL load on the clock edge; in ACCESS/DONE they SHALL be ignored.
REQ-024 In IDLE, Rd_Start or Wr_Start SHALL move to ACCESS next cycle, latch the operation, clear Err, and zero the wait counter.
REQ-025 Rd_Start and Wr_Start asserted together SHALL start a read; the write is dropped.
REQ-026 LD_MAR/LD_MDR in the same IDLE cycle as a start SHALL take effect, so the access uses the newly loaded values.
REQ-027 In ACCESS, Mem_Req=1, Mem_We=latched op, Mem_Addr=MAR, Mem_Wdata=MDR, all stable for the whole state.
REQ-028 In ACCESS with Mem_Ready=1: read SHALL load MDR<=Mem_Rdata; write leaves MDR unchanged; next state DONE.
REQ-029 In ACCESS with Mem_Ready=0: counter +1; when counter reaches TIMEOUT (TIMEOUT>0), Err<=1, MDR unchanged, next state DONE.
REQ-030 Mem_Ready=1 in the same cycle the counter hits TIMEOUT SHALL count as success; Err stays 0.
REQ-031 Counter width SHALL be clog2(TIMEOUT+1), minimum 1, saturating; no wrap-around.
REQ-032 In DONE, Done=1 for exactly one cycle and Mem_Req=0; next state IDLE unconditionally.
REQ-033 Start requests in ACCESS or DONE SHALL be ignored, not queued.
REQ-034 Mem_Ready outside ACCESS SHALL be ignored.
REQ-035 Minimum latency: start sampled at edge k, ACCESS during cycle k+1, Done during cycle k+2, IDLE at k+3.

Reset
REQ-036 Reset_n=0 at a rising edge SHALL force IDLE, MAR=0, MDR=0, Err=0, counter=0.
REQ-037 Mem_Req, Mem_We, Busy, Done SHALL be 0 in the cycle after reset.
REQ-038 Reset during ACCESS SHALL abandon the access; no Done pulse; late Mem_Ready is ignored.

Structure
REQ-039 Package mem_access_pkg SHALL hold the state enum (IDLE, ACCESS, DONE) and the op enum (OP_RD, OP_WR).
REQ-040 Sub-module wait_counter (parameter MAX; ports clr, en, hit) SHALL implement the timeout counter; MAR/MDR reuse the existing register module.

Verification
REQ-041 Read, zero wait: MAR=0x3000, Rd_Start, Mem_Ready=1 with Mem_Rdata=0xBEEF in ACCESS -> Mem_Req high 1 cycle, MDR=0xBEEF, Done 1 cycle after ACCESS, Err=0.
REQ-042 Write, 3 waits: MAR=0x0042, MDR=0x1234, Wr_Start, Ready on 4th ACCESS cycle -> Mem_We=1 and Mem_Addr/Mem_Wdata stable for 4 cycles, MDR=0x1234, one Done.
REQ-043 Timeout: TIMEOUT=15, Rd_Start, Ready never -> exactly 15 ACCESS cycles, Err=1, MDR unchanged, Done pulses; next Rd_Start clears Err.
REQ-044 Conflicts: Rd_Start+Wr_Start together -> Mem_We=0; LD_MAR with BUS=0xFFFF during ACCESS -> MAR unchanged; Start during DONE -> no second access.
REQ-045 Reset_n low on 2nd ACCESS cycle -> Mem_Req 0 next cycle, MAR=MDR=0, no Done, and Mem_Ready one cycle later is ignored.
REQ-046 Parameter sweep W=32, AW=20, TIMEOUT=0: Ready after 100 cycles -> no Err, MDR holds full 32-bit Mem_Rdata.

Source files
------------

// File: rtl/mem_access_pkg.sv
// rtl/mem_access_pkg.sv - shared state and operation encodings for the memory access controller
package mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE
  } state_t;

  typedef enum logic {
    OP_RD,
    OP_WR
  } op_t;

endpackage

// File: rtl/wait_counter.sv
// rtl/wait_counter.sv - saturating wait-cycle counter; hit flags the cycle whose increment reaches MAX
module wait_counter #(
  parameter int MAX = 15
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic hit
);

  localparam int CW     = (MAX > 0) ? $clog2(MAX + 1) : 1;
  localparam int HIT_AT = (MAX > 0) ? MAX - 1 : 0;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && cnt != CW'(MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // MAX of zero disables the timeout entirely
  assign hit = (MAX > 0) && (cnt == CW'(HIT_AT));

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MAR/MDR datapath with a single-outstanding read/write memory handshake
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int W       = 16,
  parameter int AW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic          Clk,
  input  logic          Reset_n,
  input  logic [W-1:0]  BUS,
  input  logic          LD_MAR,
  input  logic          LD_MDR,
  input  logic          Rd_Start,
  input  logic          Wr_Start,
  input  logic          Mem_Ready,
  input  logic [W-1:0]  Mem_Rdata,
  output logic          Mem_Req,
  output logic          Mem_We,
  output logic [AW-1:0] Mem_Addr,
  output logic [W-1:0]  Mem_Wdata,
  output logic [AW-1:0] MAR,
  output logic [W-1:0]  MDR,
  output logic          Busy,
  output logic          Done,
  output logic          Err
);

  state_t state, state_nxt;
  op_t    op;
  logic   start;
  logic   cnt_clr, cnt_en, cnt_hit;

  assign start = Rd_Start || Wr_Start;

  wait_counter #(.MAX(TIMEOUT)) u_wait_counter (
    .clk     (Clk),
    .reset_n (Reset_n),
    .clr     (cnt_clr),
    .en      (cnt_en),
    .hit     (cnt_hit)
  );

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = ACCESS;
          cnt_clr   = 1'b1;
        end
      end
      ACCESS: begin
        if (Mem_Ready) begin
          state_nxt = DONE;
        end else begin
          cnt_en = 1'b1;
          if (cnt_hit) state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state <= IDLE;
      op    <= OP_RD;
      MAR   <= '0;
      MDR   <= '0;
      Err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        if (LD_MAR) MAR <= BUS[AW-1:0];
        if (LD_MDR) MDR <= BUS;
        if (start) begin
          // read wins when both starts arrive together
          op  <= Rd_Start ? OP_RD : OP_WR;
          Err <= 1'b0;
        end
      end else if (state == ACCESS) begin
        if (Mem_Ready) begin
          if (op == OP_RD) MDR <= Mem_Rdata;
        end else if (cnt_hit) begin
          Err <= 1'b1;
        end
      end
    end
  end

  assign Mem_Req   = (state == ACCESS);
  assign Mem_We    = (state == ACCESS) && (op == OP_WR);
  assign Mem_Addr  = MAR;
  assign Mem_Wdata = MDR;
  assign Busy      = (state != IDLE);
  assign Done      = (state == DONE);

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - randomized transaction-level bench for mem_access_ctrl
module tb_mem_access_ctrl;

  localparam int TMO = 15;

  logic        Clk = 1'b0;
  logic        Reset_n, LD_MAR, LD_MDR, Rd_Start, Wr_Start, Mem_Ready;
  logic [15:0] BUS, Mem_Rdata, Mem_Wdata, MDR, Mem_Addr, MAR;
  logic        Mem_Req, Mem_We, Busy, Done, Err;

  logic        s_reset_n, s_ld_mar, s_ld_mdr, s_rd_start, s_wr_start, s_mem_ready;
  logic [31:0] s_bus, s_mem_rdata, s_mem_wdata, s_mdr;
  logic [19:0] s_mem_addr, s_mar;
  logic        s_mem_req, s_mem_we, s_busy, s_done, s_err;

  int checks = 0;
  int failures = 0;
  logic [15:0] m_mar, m_mdr;
  logic        m_err;

  always #5 Clk = ~Clk;

  mem_access_ctrl #(.W(16), .AW(16), .TIMEOUT(TMO)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .BUS(BUS), .LD_MAR(LD_MAR), .LD_MDR(LD_MDR),
    .Rd_Start(Rd_Start), .Wr_Start(Wr_Start), .Mem_Ready(Mem_Ready), .Mem_Rdata(Mem_Rdata),
    .Mem_Req(Mem_Req), .Mem_We(Mem_We), .Mem_Addr(Mem_Addr), .Mem_Wdata(Mem_Wdata),
    .MAR(MAR), .MDR(MDR), .Busy(Busy), .Done(Done), .Err(Err)
  );

  mem_access_ctrl #(.W(32), .AW(20), .TIMEOUT(0)) dut_wide (
    .Clk(Clk), .Reset_n(s_reset_n), .BUS(s_bus), .LD_MAR(s_ld_mar), .LD_MDR(s_ld_mdr),
    .Rd_Start(s_rd_start), .Wr_Start(s_wr_start), .Mem_Ready(s_mem_ready), .Mem_Rdata(s_mem_rdata),
    .Mem_Req(s_mem_req), .Mem_We(s_mem_we), .Mem_Addr(s_mem_addr), .Mem_Wdata(s_mem_wdata),
    .MAR(s_mar), .MDR(s_mdr), .Busy(s_busy), .Done(s_done), .Err(s_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    BUS = '0; LD_MAR = 1'b0; LD_MDR = 1'b0;
    Rd_Start = 1'b0; Wr_Start = 1'b0; Mem_Ready = 1'b0; Mem_Rdata = '0;
  endtask

  // one complete transaction: load MAR, then load MDR together with the start
  task automatic run_access(input bit rd, input bit wr, input logic [15:0] addr,
                            input logic [15:0] data, input int waits, input logic [15:0] rdata);
    bit timed_out;
    int exp_cyc, cyc;
    logic [15:0] exp_mdr;
    timed_out = (TMO > 0) && (waits >= TMO);
    exp_cyc   = timed_out ? TMO : waits + 1;
    exp_mdr   = (!timed_out && rd) ? rdata : data;

    BUS = addr; LD_MAR = 1'b1; Mem_Ready = 1'($urandom);
    @(negedge Clk);
    m_mar = addr;
    check("idle_mar", 64'(MAR), 64'(m_mar));
    LD_MAR = 1'b0; BUS = data; LD_MDR = 1'b1; Rd_Start = rd; Wr_Start = wr;
    @(negedge Clk);
    m_mdr = data;
    cyc = 0;
    while (Mem_Req === 1'b1 && cyc < 300) begin
      check("acc_we", 64'(Mem_We), 64'(!rd));
      check("acc_addr", 64'(Mem_Addr), 64'(m_mar));
      check("acc_wdata", 64'(Mem_Wdata), 64'(m_mdr));
      check("acc_busy_done", {62'd0, Busy, Done}, 64'b10);
      if (cyc == 0) check("acc_err_clr", 64'(Err), 64'd0);
      Mem_Ready = (cyc == waits);
      Mem_Rdata = (cyc == waits) ? rdata : 16'($urandom);
      BUS = 16'($urandom); LD_MAR = 1'($urandom); LD_MDR = 1'($urandom);
      Rd_Start = 1'($urandom); Wr_Start = 1'($urandom);
      @(negedge Clk);
      cyc++;
    end
    check("acc_cycles", 64'(cyc), 64'(exp_cyc));
    check("done_pulse", {61'd0, Done, Mem_Req, Busy}, 64'b101);
    check("done_err", 64'(Err), 64'(timed_out));
    check("done_mdr", 64'(MDR), 64'(exp_mdr));
    check("done_mar", 64'(MAR), 64'(m_mar));
    Rd_Start = 1'b1; Wr_Start = 1'($urandom); LD_MAR = 1'b1; LD_MDR = 1'b1;
    BUS = 16'($urandom); Mem_Ready = 1'($urandom);
    @(negedge Clk);
    check("post_idle", {61'd0, Done, Mem_Req, Busy}, 64'b000);
    check("post_mar", 64'(MAR), 64'(m_mar));
    check("post_mdr", 64'(MDR), 64'(exp_mdr));
    idle_inputs();
    @(negedge Clk);
    check("no_requeue", {62'd0, Mem_Req, Busy}, 64'b00);
    m_err = timed_out;
    m_mdr = exp_mdr;
    check("hold_err", 64'(Err), 64'(m_err));
  endtask

  initial begin
    bit rd, wr;
    int waits;
    idle_inputs();
    s_bus = '0; s_ld_mar = 0; s_ld_mdr = 0; s_rd_start = 0; s_wr_start = 0;
    s_mem_ready = 0; s_mem_rdata = '0; s_reset_n = 1'b0;
    Reset_n = 1'b0;
    BUS = 16'hFFFF; LD_MAR = 1'b1; LD_MDR = 1'b1; Rd_Start = 1'b1;
    repeat (3) @(negedge Clk);
    idle_inputs();
    m_mar = '0; m_mdr = '0; m_err = 1'b0;
    check("rst_regs", {MAR, MDR}, 64'd0);
    check("rst_flags", {59'd0, Mem_Req, Mem_We, Busy, Done, Err}, 64'd0);
    Reset_n = 1'b1;
    s_reset_n = 1'b1;
    @(negedge Clk);

    run_access(1, 0, 16'h3000, 16'h0000, 0, 16'hBEEF);
    run_access(0, 1, 16'h0042, 16'h1234, 3, 16'h5555);
    run_access(1, 0, 16'h0100, 16'h7777, 40, 16'h1111);
    run_access(1, 0, 16'h0101, 16'h8888, 0, 16'h2222);
    run_access(1, 1, 16'h0200, 16'h9999, 2, 16'h3333);
    run_access(1, 0, 16'h0300, 16'hAAAA, TMO - 1, 16'h4444);
    run_access(0, 1, 16'h0400, 16'hBBBB, TMO, 16'h6666);
    for (int i = 0; i < 30; i++) begin
      rd    = 1'($urandom);
      wr    = rd ? 1'($urandom) : 1'b1;
      waits = $urandom_range(0, TMO + 3);
      run_access(rd, wr, 16'($urandom), 16'($urandom), waits, 16'($urandom));
    end

    // reset in the second ACCESS cycle abandons the access
    BUS = 16'h5A5A; LD_MAR = 1'b1; LD_MDR = 1'b1; Rd_Start = 1'b1;
    @(negedge Clk);
    idle_inputs();
    check("rst_acc1", 64'(Mem_Req), 64'd1);
    @(negedge Clk);
    check("rst_acc2", 64'(Mem_Req), 64'd1);
    Reset_n = 1'b0;
    @(negedge Clk);
    check("rst_mid_regs", {MAR, MDR}, 64'd0);
    check("rst_mid_flags", {60'd0, Mem_Req, Busy, Done, Err}, 64'd0);
    Reset_n = 1'b1; Mem_Ready = 1'b1; Mem_Rdata = 16'hCAFE;
    @(negedge Clk);
    idle_inputs();
    check("late_ready", {46'd0, MDR, Mem_Req, Done}, 64'd0);
    @(negedge Clk);
    check("late_ready_idle", {62'd0, Busy, Done}, 64'd0);

    // wide instance, timeout disabled
    s_bus = 32'h000A_BCDE; s_ld_mar = 1'b1; s_mem_ready = 1'b1;
    @(negedge Clk);
    s_ld_mar = 1'b0; s_rd_start = 1'b1; s_mem_ready = 1'b0;
    @(negedge Clk);
    s_rd_start = 1'b0;
    waits = 0;
    while (s_mem_req === 1'b1 && waits < 300) begin
      s_mem_ready = (waits == 100);
      s_mem_rdata = (waits == 100) ? 32'hDEAD_BEEF : $urandom;
      @(negedge Clk);
      waits++;
    end
    s_mem_ready = 1'b0;
    check("wide_cycles", 64'(waits), 64'd101);
    check("wide_done", {62'd0, s_done, s_err}, 64'b10);
    check("wide_mdr", 64'(s_mdr), 64'hDEAD_BEEF);
    check("wide_addr", 64'(s_mem_addr), 64'h000A_BCDE);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
